mem_access_ctrl: RTL

- Sequences every access to the byte-addressed RAM over its MOV/ReadWrite/MS_2_0/MOC/MOCoff handshake.
- Arbitrates between two requesters: instruction fetch (IF, word reads only) and data (D, load/store, any size).
- Applies the alignment check and a MOC timeout, then returns read data and a one-cycle done pulse to the granted requester.
- Sits between the CPU control unit/datapath and the RAM.

---
 rtl/mem_pkg.sv | 23 ++
 rtl/mem_align_chk.sv | 20 ++
 rtl/mem_access_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the RAM access controller.
package mem_pkg;

    localparam logic [1:0] MS_BYTE = 2'b00;
    localparam logic [1:0] MS_HALF = 2'b01;
    localparam logic [1:0] MS_WORD = 2'b10;
    localparam int         MS_SIGN = 2;

    localparam int DEF_TIMEOUT = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MOC = 2'd1,
        RELEASE  = 2'd2,
        FAULT    = 2'd3
    } state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_D  = 1'b1
    } grant_t;

endpackage

// File: rtl/mem_align_chk.sv
// Alignment check for one RAM access: size code against the low address bits.
module mem_align_chk
    import mem_pkg::*;
(
    input  logic [1:0] size,
    input  logic [1:0] addr,
    output logic       misaligned
);

    always_comb begin
        misaligned = 1'b1;
        case (size)
            MS_BYTE: misaligned = 1'b0;
            MS_HALF: misaligned = addr[0];
            MS_WORD: misaligned = (addr != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// RAM access controller: IF/D arbitration, MOV/MOC handshake, alignment and timeout.
// Define MEM_ACCESS_CTRL_RR_EN for round-robin arbitration instead of fixed D>IF.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_done,
    output logic [DW-1:0] if_rdata,
    output logic          if_err,
    input  logic          d_req,
    input  logic          d_rw,
    input  logic [2:0]    d_size,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_done,
    output logic [DW-1:0] d_rdata,
    output logic          d_err,
    output logic          mem_mov,
    output logic          mem_rw,
    output logic [2:0]    mem_ms,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    output logic          mem_mocoff,
    input  logic          mem_moc,
    input  logic [DW-1:0] mem_dout
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t        state, state_n;
    grant_t        gnt, gnt_n;
    logic [7:0]    cnt, cnt_n;
    logic          mov_n, rw_n, mocoff_n;
    logic [2:0]    ms_n;
    logic [AW-1:0] addr_n;
    logic [DW-1:0] din_n, if_rdata_n, d_rdata_n;
    logic          if_done_n, if_err_n, d_done_n, d_err_n;

    logic          issue, sel_d, misaligned;
    logic [2:0]    sel_size;
    logic [AW-1:0] sel_addr;
    logic          fin, fin_err, fin_load, fin_zero;

    assign issue = (d_req || if_req) && !mem_moc;

`ifdef MEM_ACCESS_CTRL_RR_EN
    grant_t last_grant;

    assign sel_d = d_req && (!if_req || last_grant == GNT_IF);

    // Only contested grants move the pointer; a lone requester does not.
    always_ff @(posedge clk) begin
        if (reset)
            last_grant <= GNT_IF;
        else if (state == IDLE && issue && d_req && if_req)
            last_grant <= sel_d ? GNT_D : GNT_IF;
    end
`else
    assign sel_d = d_req;
`endif

    assign sel_size = sel_d ? d_size : {1'b0, MS_WORD};
    assign sel_addr = sel_d ? d_addr : if_addr;

    mem_align_chk u_align (
        .size       (sel_size[1:0]),
        .addr       (sel_addr[1:0]),
        .misaligned (misaligned)
    );

    always_comb begin
        state_n    = state;
        gnt_n      = gnt;
        cnt_n      = cnt;
        mov_n      = mem_mov;
        rw_n       = mem_rw;
        ms_n       = mem_ms;
        addr_n     = mem_addr;
        din_n      = mem_din;
        mocoff_n   = 1'b0;
        if_rdata_n = if_rdata;
        d_rdata_n  = d_rdata;
        if_done_n  = 1'b0;
        if_err_n   = 1'b0;
        d_done_n   = 1'b0;
        d_err_n    = 1'b0;
        fin        = 1'b0;
        fin_err    = 1'b0;
        fin_load   = 1'b0;
        fin_zero   = 1'b0;

        case (state)
            IDLE: begin
                if (issue) begin
                    gnt_n = sel_d ? GNT_D : GNT_IF;
                    if (misaligned) begin
                        state_n = FAULT;
                    end else begin
                        mov_n   = 1'b1;
                        rw_n    = sel_d ? d_rw : 1'b1;
                        ms_n    = sel_size;
                        addr_n  = sel_addr;
                        din_n   = sel_d ? d_wdata : '0;
                        cnt_n   = 8'd0;
                        state_n = WAIT_MOC;
                    end
                end
            end
            WAIT_MOC: begin
                if (mem_moc) begin
                    mov_n    = 1'b0;
                    mocoff_n = 1'b1;
                    fin      = 1'b1;
                    fin_load = mem_rw;
                    state_n  = RELEASE;
                end else if (cnt == TO_LAST) begin
                    mov_n    = 1'b0;
                    mocoff_n = 1'b1;
                    fin      = 1'b1;
                    fin_err  = 1'b1;
                    state_n  = RELEASE;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            RELEASE: state_n = IDLE;
            FAULT: begin
                fin      = 1'b1;
                fin_err  = 1'b1;
                fin_zero = 1'b1;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase

        if (fin) begin
            if (gnt == GNT_D) begin
                d_done_n = 1'b1;
                d_err_n  = fin_err;
                if (fin_load) d_rdata_n = mem_dout;
                if (fin_zero) d_rdata_n = '0;
            end else begin
                if_done_n = 1'b1;
                if_err_n  = fin_err;
                if (fin_load) if_rdata_n = mem_dout;
                if (fin_zero) if_rdata_n = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            gnt        <= GNT_IF;
            cnt        <= 8'd0;
            mem_mov    <= 1'b0;
            mem_rw     <= 1'b0;
            mem_ms     <= 3'b000;
            mem_addr   <= '0;
            mem_din    <= '0;
            mem_mocoff <= 1'b1;
            if_rdata   <= '0;
            d_rdata    <= '0;
            if_done    <= 1'b0;
            if_err     <= 1'b0;
            d_done     <= 1'b0;
            d_err      <= 1'b0;
        end else begin
            state      <= state_n;
            gnt        <= gnt_n;
            cnt        <= cnt_n;
            mem_mov    <= mov_n;
            mem_rw     <= rw_n;
            mem_ms     <= ms_n;
            mem_addr   <= addr_n;
            mem_din    <= din_n;
            mem_mocoff <= mocoff_n;
            if_rdata   <= if_rdata_n;
            d_rdata    <= d_rdata_n;
            if_done    <= if_done_n;
            if_err     <= if_err_n;
            d_done     <= d_done_n;
            d_err      <= d_err_n;
        end
    end

endmodule
